// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control path.
package booth_pkg;

  localparam int   DEFAULT_WIDTH = 16;
  localparam int   DEFAULT_CNT_W = 5;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    CHECK,
    ARITH,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/booth_ctrl_if.sv
// Strobe/status bundle between the Booth controller (master) and its datapath (slave).
interface booth_ctrl_if;

  logic q0;
  logic qm1;
  logic eqz;
  logic data_sel;
  logic ldA;
  logic ldQ;
  logic ldM;
  logic clrA;
  logic clrQ;
  logic clrff;
  logic sftA;
  logic sftQ;
  logic addsub;
  logic decr;
  logic ldcnt;

  modport master (
    input  q0, qm1, eqz,
    output data_sel, ldA, ldQ, ldM, clrA, clrQ, clrff,
           sftA, sftQ, addsub, decr, ldcnt
  );

  modport slave (
    output q0, qm1, eqz,
    input  data_sel, ldA, ldQ, ldM, clrA, clrQ, clrff,
           sftA, sftQ, addsub, decr, ldcnt
  );

endinterface

// File: rtl/booth_ctrl.sv
// Control FSM sequencing the radix-2 Booth multiplier datapath: load M, load Q,
// then WIDTH check/add-sub/shift iterations, ending in a one-cycle done pulse.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  booth_ctrl_if.master        dp
);

  state_t state_q, state_d;
  logic   data_sel_q, data_sel_d;
  logic   addsub_q, addsub_d;

  // data_sel and addsub are captured on the transition into the state that uses
  // them, so they are already valid during that state and hold afterwards.
  always_comb begin
    state_d    = state_q;
    data_sel_d = data_sel_q;
    addsub_d   = addsub_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_M;
          data_sel_d = 1'b0;
        end
      end
      LOAD_M: begin
        state_d    = LOAD_Q;
        data_sel_d = 1'b1;
      end
      LOAD_Q: state_d = CHECK;
      CHECK: begin
        if (dp.eqz) begin
          state_d = DONE;
        end else if ({dp.q0, dp.qm1} == 2'b10) begin
          state_d  = ARITH;
          addsub_d = ALU_SUB;
        end else if ({dp.q0, dp.qm1} == 2'b01) begin
          state_d  = ARITH;
          addsub_d = ALU_ADD;
        end else begin
          state_d = SHIFT;
        end
      end
      ARITH:   state_d = SHIFT;
      SHIFT:   state_d = CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_sel_q <= 1'b0;
      addsub_q   <= ALU_SUB;
    end else begin
      state_q    <= state_d;
      data_sel_q <= data_sel_d;
      addsub_q   <= addsub_d;
    end
  end

  assign dp.data_sel = data_sel_q;
  assign dp.addsub   = addsub_q;
  assign dp.ldM      = (state_q == LOAD_M);
  assign dp.clrA     = (state_q == LOAD_M);
  assign dp.clrff    = (state_q == LOAD_M);
  assign dp.ldcnt    = (state_q == LOAD_M);
  assign dp.ldQ      = (state_q == LOAD_Q);
  assign dp.ldA      = (state_q == ARITH);
  assign dp.sftA     = (state_q == SHIFT);
  assign dp.sftQ     = (state_q == SHIFT);
  assign dp.decr     = (state_q == SHIFT);
  // Q is always loaded before it is examined, so it never needs clearing.
  assign dp.clrQ     = 1'b0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: a behavioural Booth datapath closes the loop
// so hand-computed products, latencies and add/sub sequences can be checked.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mcand = 16'h0000;
  logic [15:0] mult  = 16'h0000;
  logic [15:0] a_r   = 16'h0000;
  logic [15:0] q_r   = 16'h0000;
  logic [15:0] m_r   = 16'h0000;
  logic        qm1_r = 1'b0;
  logic [4:0]  cnt_r = 5'd0;
  logic [15:0] data_in;

  booth_ctrl_if dp ();

  booth_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  assign data_in = dp.data_sel ? mult : mcand;
  assign dp.q0   = q_r[0];
  assign dp.qm1  = qm1_r;
  assign dp.eqz  = (cnt_r == 5'd0);

  // Behavioural datapath reacting to the controller strobes.
  always @(posedge clk) begin
    if (dp.ldcnt) cnt_r <= 5'd16;
    else if (dp.decr) cnt_r <= cnt_r - 5'd1;
    if (dp.ldM) m_r <= data_in;
    if (dp.ldQ) q_r <= data_in;
    if (dp.clrff) qm1_r <= 1'b0;
    if (dp.clrA) a_r <= 16'h0000;
    else if (dp.ldA) a_r <= dp.addsub ? (a_r + m_r) : (a_r - m_r);
    else if (dp.sftA && dp.sftQ) {a_r, q_r, qm1_r} <= {a_r[15], a_r, q_r};
  end

  function automatic logic [10:0] strobes();
    return {dp.data_sel, dp.ldA, dp.ldQ, dp.ldM, dp.clrA, dp.clrQ,
            dp.clrff, dp.sftA, dp.sftQ, dp.decr, dp.ldcnt};
  endfunction

  localparam logic [10:0] LOAD_M_STROBES = 11'b0_0_0_1_1_0_1_0_0_0_1;
  localparam logic [10:0] LOAD_Q_STROBES = 11'b1_0_1_0_0_0_0_0_0_0_0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one multiply; optionally re-pulses start mid-operation.
  task automatic applyStimulus(input string tag, input logic [15:0] mc,
                               input logic [15:0] mp, input logic [31:0] exp_prod,
                               input int exp_arith, input int exp_lat,
                               input logic [15:0] exp_seq, input bit repulse);
    int          cyc;
    int          arith;
    int          done_cyc;
    bit          clrq_seen;
    logic [15:0] seq;
    cyc       = 1;
    arith     = 0;
    done_cyc  = 0;
    clrq_seen = 1'b0;
    seq       = 16'h0000;
    mcand     = mc;
    mult      = mp;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy_start"}, {31'd0, busy}, 32'd1);
    while (cyc <= 100 && done_cyc == 0) begin
      if (dp.ldM) checkOutput({tag, " load_m_strobes"}, {21'd0, strobes()}, {21'd0, LOAD_M_STROBES});
      if (dp.ldQ) checkOutput({tag, " load_q_strobes"}, {21'd0, strobes()}, {21'd0, LOAD_Q_STROBES});
      if (dp.ldA) begin
        if (arith < 16) seq[arith] = dp.addsub;
        arith++;
      end
      if (dp.clrQ) clrq_seen = 1'b1;
      if (done) begin
        done_cyc = cyc;
        checkOutput({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
      end
      if (repulse && cyc == 10) start = 1'b1;
      if (repulse && cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, done_cyc, exp_lat);
    checkOutput({tag, " arith_visits"}, arith, exp_arith);
    checkOutput({tag, " addsub_seq"}, {16'd0, seq}, {16'd0, exp_seq});
    checkOutput({tag, " product"}, {a_r, q_r}, exp_prod);
    checkOutput({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " clrq_never"}, {31'd0, clrq_seen}, 32'd0);
  endtask

  initial begin
    int shifts;
    $display("[TB] booth_ctrl directed test");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_strobes", {21'd0, strobes()}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_addsub", {31'd0, dp.addsub}, 32'd0);
    rst = 1'b0;

    applyStimulus("m3_q5",   16'h0003, 16'h0005, 32'h0000_000F, 4,  40, 16'h000A, 1'b0);
    applyStimulus("mneg2_q7", 16'hFFFE, 16'h0007, 32'hFFFF_FFF2, 2,  38, 16'h0002, 1'b0);
    applyStimulus("q_zero",  16'h1234, 16'h0000, 32'h0000_0000, 0,  36, 16'h0000, 1'b0);
    applyStimulus("q_5555",  16'h0001, 16'h5555, 32'h0000_5555, 16, 52, 16'hAAAA, 1'b0);
    applyStimulus("repulse", 16'h0003, 16'h0005, 32'h0000_000F, 4,  40, 16'h000A, 1'b1);

    // Abort mid-operation after the fifth shift; the last ARITH before it was an add.
    mcand = 16'h0003;
    mult  = 16'h000A;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    shifts = 0;
    for (int i = 0; i < 100 && shifts < 5; i++) begin
      if (dp.decr) shifts++;
      if (shifts < 5) @(negedge clk);
    end
    checkOutput("abort_reached_iter5", shifts, 5);
    checkOutput("abort_addsub_before", {31'd0, dp.addsub}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_strobes", {21'd0, strobes()}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_addsub", {31'd0, dp.addsub}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle_hold", {31'd0, busy}, 32'd0);

    applyStimulus("after_abort", 16'h0010, 16'h0003, 32'h0000_0030, 2, 38, 16'h0002, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
Control FSM that sequences the 16-bit radix-2 Booth multiplier datapath (A/Q shift registers, Q-1 flip-flop, M register, add/sub ALU, iteration counter). It accepts a start request, steers multiplicand then multiplier onto the shared data_in bus, and runs WIDTH add/sub/shift iterations. It then signals done, with the 2*WIDTH-bit product left in {A,Q}. It is the only driver of the datapath's load/clear/shift/count strobes.

Parameters:
WIDTH, 16, operand width; the datapath counter reloads to WIDTH on ldcnt
CNT_W, 5, counter width, must be at least clog2(WIDTH+1)

Ports:
clk  input  1  rising-edge clock shared with datapath
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
q0  input  1  datapath Q[0]
qm1  input  1  datapath Q-1 flip-flop
eqz  input  1  datapath counter == 0
data_sel  output  1  external data_in mux steer: 0 = multiplicand, 1 = multiplier
ldA  output  1  load A from ALU result
ldQ  output  1  load Q from data_in
ldM  output  1  load M from data_in
clrA  output  1  clear A
clrQ  output  1  clear Q (never asserted in normal flow, held 0)
clrff  output  1  clear Q-1 flip-flop
sftA  output  1  arithmetic right shift A
sftQ  output  1  right shift Q, A[0] into MSB
addsub  output  1  ALU op: 1 = A+M, 0 = A-M
decr  output  1  decrement counter
ldcnt  output  1  load counter with WIDTH
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at completion

Behaviour:
- All outputs are Moore, decoded from the state register. data_sel and addsub are additionally registered, so they hold their last value when not in use.
- Reset: rst=1 at a clock edge forces IDLE. All strobes, busy and done = 0; data_sel = 0; addsub = 0. Reset mid-operation aborts immediately; datapath contents are don't-care.
- IDLE: if start=1 -> LOAD_M.
- LOAD_M: ldM=1, clrA=1, clrff=1, ldcnt=1, data_sel=0. Requester must drive the multiplicand on data_in this cycle. -> LOAD_Q.
- LOAD_Q: ldQ=1, data_sel=1. Requester drives the multiplier. -> CHECK.
- CHECK (no strobes) is evaluated in priority order:
  - eqz=1 -> DONE.
  - {q0,qm1}=2'b10 -> ARITH with addsub=0 (subtract).
  - {q0,qm1}=2'b01 -> ARITH with addsub=1 (add).
  - {q0,qm1}=2'b00 or 2'b11 -> SHIFT.
- ARITH: ldA=1 with the registered addsub. -> SHIFT.
- SHIFT: sftA=1, sftQ=1, decr=1. The datapath captures the old Q[0] into Q-1 on the same edge. -> CHECK.
- DONE: done=1, busy=1 for exactly one cycle. -> IDLE. The product is valid in {A,Q} from this cycle until the next LOAD_M.
- start while busy is ignored and not queued. start held high from DONE re-launches from IDLE on the following cycle.
- Latency from the start-sampled edge to the done cycle is 4 + 2*WIDTH + (number of ARITH visits) cycles. For WIDTH=16 the range is 36 to 52.
- eqz is checked before the Booth bits, so a counter already at 0 (only if WIDTH=0 is misconfigured) ends the operation without iterating.
- clrQ is never asserted; an undriven Q is not possible because LOAD_Q always precedes CHECK.

Decomposition:
- Shared package booth_pkg holds:
  - state enum: IDLE, LOAD_M, LOAD_Q, CHECK, ARITH, SHIFT, DONE
  - constants ALU_ADD=1'b1, ALU_SUB=1'b0
  - default WIDTH
- Single flat module, no sub-module: a two-process FSM (state register plus next-state/output decode).
- A top-level wrapper connecting booth_ctrl to the datapath is a separate, later block.

Test Plan:
- M=3, Q=5, start pulse -> done at cycle 36+(ARITH count) with {A,Q}=0x0000_000F. addsub sequence observed matches the Booth bit pairs.
- M=0xFFFE (-2), Q=7 -> {A,Q}=0xFFFF_FFF2 (-14). Exactly 2 ARITH visits (sub at bit0, add at bit3), done at cycle 38.
- Q=0x0000, any M -> zero ARITH visits, 16 SHIFT visits, done 36 cycles after start, product 0.
- Q=0x5555, M=1 -> 16 ARITH visits, done at cycle 52, product 0x0000_5555.
- start re-pulsed during an operation -> no effect: same latency and result. Then rst=1 asserted at iteration 5 -> next cycle busy=0, all strobes 0, state IDLE. A new start then completes correctly.
- Per-state strobe check: LOAD_M asserts only ldM/clrA/clrff/ldcnt with data_sel=0. LOAD_Q asserts only ldQ with data_sel=1. done is high for exactly 1 cycle; clrQ is never 1.
